// File: rtl/cmp_seq_if.sv
// Handshake and operand/result bundle for the slice-serial comparator sequencer.
interface cmp_seq_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             e0;
    logic             g0;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CW-1:0]    slice_idx;

    modport master (
        output start, abort, a, b, e0, g0,
        input  busy, done, res_valid, eq, gt, lt, slice_idx
    );

    modport slave (
        input  start, abort, a, b, e0, g0,
        output busy, done, res_valid, eq, gt, lt, slice_idx
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Compares two WIDTH-bit unsigned operands with one 2-bit cascadable slice,
// walked LSB pair to MSB pair over WIDTH/2 cycles.
module cmp_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    cmp_seq_if.slave   bus
);
    localparam int unsigned CW  = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam int unsigned NSL = WIDTH / 2;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             acc_eq_q, acc_eq_d;
    logic             acc_gt_q, acc_gt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rv_q, rv_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [1:0]       pa, pb;
    logic             nx_eq, nx_gt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            acc_eq_q <= 1'b0;
            acc_gt_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            acc_eq_q <= acc_eq_d;
            acc_gt_q <= acc_gt_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    // Next-state, slice evaluation and commit
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        acc_eq_d = acc_eq_q;
        acc_gt_d = acc_gt_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        rv_d     = rv_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;

        // A differing higher pair overrides whatever the lower pairs decided
        pa    = a_sr_q[1:0];
        pb    = b_sr_q[1:0];
        nx_eq = acc_eq_q;
        nx_gt = acc_gt_q;
        if (pa != pb) begin
            nx_eq = 1'b0;
            nx_gt = (pa > pb);
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    acc_eq_d = bus.e0;
                    acc_gt_d = bus.g0;
                    idx_d    = '0;
                    rv_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    acc_eq_d = nx_eq;
                    acc_gt_d = nx_gt;
                    a_sr_d   = a_sr_q >> 2;
                    b_sr_d   = b_sr_q >> 2;
                    if (idx_q == LAST) begin
                        eq_d    = nx_eq;
                        gt_d    = nx_gt;
                        lt_d    = ~nx_eq & ~nx_gt;
                        rv_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = rv_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.slice_idx = idx_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: cycle model check on an 8-bit instance,
// directed literal checks, and an exhaustive sweep on a 4-bit instance.
module tb_cmp_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmp_seq_if #(.WIDTH(8)) i8 ();
    cmp_seq_if #(.WIDTH(4)) i4 ();

    cmp_seq_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    cmp_seq_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the 8-bit instance: result is plain arithmetic,
    // timing is a countdown of remaining slices.
    logic       m_busy, m_done, m_rv, m_eq, m_gt, m_lt, p_eq, p_gt;
    logic [1:0] m_idx;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_rv <= 1'b0;
            m_eq   <= 1'b0; m_gt   <= 1'b0; m_lt <= 1'b0;
            p_eq   <= 1'b0; p_gt   <= 1'b0;
            m_idx  <= 2'd0; m_left <= 0;
        end else if (m_busy) begin
            if (i8.abort) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_rv <= 1'b1;
                m_eq   <= p_eq; m_gt   <= p_gt; m_lt <= !p_eq && !p_gt;
            end else begin
                m_left <= m_left - 1;
                m_idx  <= m_idx + 2'd1;
            end
        end else begin
            m_done <= 1'b0;
            if (i8.start) begin
                m_busy <= 1'b1; m_left <= 4; m_idx <= 2'd0; m_rv <= 1'b0;
                p_eq   <= (i8.a == i8.b) && i8.e0;
                p_gt   <= (i8.a == i8.b) ? i8.g0 : (i8.a > i8.b);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("m_busy",  32'(i8.busy),      32'(m_busy));
            check("m_done",  32'(i8.done),      32'(m_done));
            check("m_rv",    32'(i8.res_valid), 32'(m_rv));
            check("m_eq",    32'(i8.eq),        32'(m_eq));
            check("m_gt",    32'(i8.gt),        32'(m_gt));
            check("m_lt",    32'(i8.lt),        32'(m_lt));
            check("m_idx",   32'(i8.slice_idx), 32'(m_idx));
        end
    end

    task automatic chk_res(input string nm, input logic e, input logic g, input logic l);
        check({nm, "_eq"}, 32'(i8.eq), 32'(e));
        check({nm, "_gt"}, 32'(i8.gt), 32'(g));
        check({nm, "_lt"}, 32'(i8.lt), 32'(l));
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_busy"}, 32'(i8.busy),      32'd0);
        check({nm, "_done"}, 32'(i8.done),      32'd0);
        check({nm, "_rv"},   32'(i8.res_valid), 32'd0);
        check({nm, "_idx"},  32'(i8.slice_idx), 32'd0);
        chk_res(nm, 1'b0, 1'b0, 1'b0);
    endtask

    // One operation on the 8-bit instance; lat counts edges from the accept edge
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic te0,
                        input logic tg0, input int abort_at, input bit pulse, output int lat);
        @(negedge clk);
        i8.a = ta; i8.b = tb; i8.e0 = te0; i8.g0 = tg0; i8.abort = 1'b0; i8.start = 1'b1;
        @(negedge clk);
        i8.start = 1'b0;
        i8.a = ta ^ 8'hA5; i8.b = ~tb; i8.e0 = ~te0; i8.g0 = ~tg0;
        lat = 1;
        while (!i8.done && lat < 12) begin
            i8.abort = (lat + 1 == abort_at);
            i8.start = pulse && (lat == 2);
            @(negedge clk);
            lat++;
        end
        i8.abort = 1'b0;
        i8.start = 1'b0;
    endtask

    logic [7:0] ba [4];
    logic [7:0] bb [4];
    logic [2:0] bx [4];

    initial begin
        int lat, k, cyc, last, w;
        logic ex, gx, lx;
        ba = '{8'h12, 8'hF0, 8'hAA, 8'h01};
        bb = '{8'h34, 8'h0F, 8'hAA, 8'h00};
        bx = '{3'b001, 3'b010, 3'b100, 3'b010};   // {eq, gt, lt}

        i8.start = 1'b0; i8.abort = 1'b0; i8.a = '0; i8.b = '0; i8.e0 = 1'b0; i8.g0 = 1'b0;
        i4.start = 1'b0; i4.abort = 1'b0; i4.a = '0; i4.b = '0; i4.e0 = 1'b0; i4.g0 = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run8(8'h80, 8'h7F, 1'b1, 1'b0, 0, 1'b0, lat);
        chk_res("mag_gt", 1'b0, 1'b1, 1'b0);
        check("mag_rv", 32'(i8.res_valid), 32'd1);
        run8(8'h7F, 8'h80, 1'b1, 1'b0, 0, 1'b0, lat);
        chk_res("mag_lt", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges, mid-RUN
        @(negedge clk);
        i8.a = 8'h11; i8.b = 8'h22; i8.e0 = 1'b1; i8.g0 = 1'b0; i8.start = 1'b1;
        @(negedge clk);
        i8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy", 32'(i8.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'h5A, 8'h5A, 1'b1, 1'b0, 0, 1'b0, lat);
        check("lat_5a", 32'(lat), 32'd5);
        chk_res("eq_5a", 1'b1, 1'b0, 1'b0);

        run8(8'h3C, 8'h3C, 1'b1, 1'b1, 0, 1'b0, lat);
        chk_res("casc_e1g1", 1'b1, 1'b1, 1'b0);
        run8(8'h3C, 8'h3C, 1'b0, 1'b1, 0, 1'b0, lat);
        chk_res("casc_e0g1", 1'b0, 1'b1, 1'b0);
        run8(8'h41, 8'h42, 1'b1, 1'b0, 0, 1'b0, lat);
        chk_res("lsb_pair", 1'b0, 1'b0, 1'b1);

        // Abort on the 3rd RUN edge, then on the final-slice edge
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 4, 1'b0, lat);
        check("abort3_nodone", 32'(lat), 32'd12);
        check("abort3_rv", 32'(i8.res_valid), 32'd0);
        check("abort3_busy", 32'(i8.busy), 32'd0);
        chk_res("abort3_keep", 1'b0, 1'b0, 1'b1);
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 5, 1'b0, lat);
        check("abortL_nodone", 32'(lat), 32'd12);
        check("abortL_rv", 32'(i8.res_valid), 32'd0);
        chk_res("abortL_keep", 1'b0, 1'b0, 1'b1);

        // start pulsed while RUN must be ignored
        run8(8'h10, 8'h20, 1'b1, 1'b0, 0, 1'b1, lat);
        check("pulse_lat", 32'(lat), 32'd5);
        chk_res("pulse_res", 1'b0, 1'b0, 1'b1);

        // Back-to-back with start held high
        @(negedge clk);
        i8.a = ba[0]; i8.b = bb[0]; i8.e0 = 1'b1; i8.g0 = 1'b0; i8.start = 1'b1;
        k = 0; cyc = 0; last = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i8.done) begin
                chk_res("b2b", bx[k][2], bx[k][1], bx[k][0]);
                if (k > 0) check("b2b_period", 32'(cyc - last), 32'd5);
                last = cyc;
                k++;
                if (k < 4) begin
                    i8.a = ba[k]; i8.b = bb[k];
                end else begin
                    i8.start = 1'b0;
                end
            end
        end
        i8.start = 1'b0;
        check("b2b_count", 32'(k), 32'd4);

        // Exhaustive sweep of the 4-bit instance
        for (int c = 0; c < 4; c++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(negedge clk);
                    i4.a = 4'(x); i4.b = 4'(y); i4.e0 = c[1]; i4.g0 = c[0]; i4.start = 1'b1;
                    @(negedge clk);
                    i4.start = 1'b0;
                    w = 0;
                    while (!i4.done && w < 8) begin
                        @(negedge clk);
                        w++;
                    end
                    ex = (x == y) && c[1];
                    gx = (x == y) ? c[0] : (x > y);
                    lx = !ex && !gx;
                    check("w4_lat", 32'(w), 32'd2);
                    check("w4_eq", 32'(i4.eq), 32'(ex));
                    check("w4_gt", 32'(i4.gt), 32'(gx));
                    check("w4_lt", 32'(i4.lt), 32'(lx));
                end
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
